// File: rtl/learn_mode_tutor_if.sv
// Handshake and data bundle between the learn-mode tutor, song memory, key inputs and display.
// master drives keys/memory data/commands; slave is the tutor itself.
interface learn_mode_tutor_if #(
  parameter int NUM_KEYS = 8,
  parameter int OCT_W    = 2,
  parameter int CNT_W    = 8
);
  logic                      start;
  logic                      abort;
  logic [NUM_KEYS-1:0]       buts;
  logic [OCT_W-1:0]          octave;
  logic [NUM_KEYS+OCT_W-1:0] note_in;
  logic                      note_last;
  logic                      read_en;
  logic                      hit;
  logic                      miss;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          hit_cnt;
  logic [CNT_W-1:0]          miss_cnt;
  logic [CNT_W-1:0]          wrong_cnt;

  modport master (
    output start, abort, buts, octave, note_in, note_last,
    input  read_en, hit, miss, busy, done, hit_cnt, miss_cnt, wrong_cnt
  );

  modport slave (
    input  start, abort, buts, octave, note_in, note_last,
    output read_en, hit, miss, busy, done, hit_cnt, miss_cnt, wrong_cnt
  );
endinterface

// File: rtl/learn_mode_tutor.sv
// Learn-mode controller: walks a song note by note, scores hits/misses/wrong presses.
// Optional per-note timeout and miss statistics are built when LEARN_TIMEOUT_EN is defined.
module learn_mode_tutor #(
  parameter int NUM_KEYS    = 8,
  parameter int OCT_W       = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  learn_mode_tutor_if.slave  bus
);
  localparam int NW = NUM_KEYS + OCT_W;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("learn_mode_tutor: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ARM, S_LISTEN, S_DONE} state_t;

  state_t            state, nxt;
  logic [NW-1:0]     key_word;
  logic              rest_note, match, decide_en, clear_cnt;
  logic              hit_p0, wrong_p0, hit_p1, miss_p1, buts_zero_p1;
  logic [CNT_W-1:0]  hit_cnt_r, wrong_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Pressed keys rearranged into memory order (key 0 in the MSB) followed by the octave.
  always_comb begin
    key_word = '0;
    for (int i = 0; i < NUM_KEYS; i++) key_word[NW-1-i] = bus.buts[i];
    key_word[OCT_W-1:0] = bus.octave;
  end

  assign rest_note = (bus.note_in[NW-1:OCT_W] == '0);
  assign match     = rest_note ? (bus.buts == '0) : (key_word == bus.note_in);
  // While a hit/miss pulse is showing the note is already decided.
  assign decide_en = (state == S_LISTEN) && !(hit_p1 || miss_p1) && !bus.abort;
  assign hit_p0    = decide_en && match;
  assign wrong_p0  = decide_en && !match && (bus.buts != '0) && buts_zero_p1;
  assign clear_cnt = !bus.abort && bus.start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (bus.abort) nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:   if (bus.start) nxt = S_FETCH;
        S_FETCH:  nxt = S_LOAD;
        S_LOAD:   nxt = bus.note_last ? S_DONE : S_ARM;
        S_ARM:    if (bus.buts == '0) nxt = S_LISTEN;
        S_LISTEN: if (hit_p1 || miss_p1) nxt = S_FETCH;
        S_DONE:   if (bus.start) nxt = S_FETCH;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.read_en = (state == S_FETCH) && !bus.abort;
    bus.busy    = (state != S_IDLE) && (state != S_DONE);
    bus.done    = (state == S_DONE);
  end

  // ---- decision stage -> registered pulses and statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1       <= 1'b0;
      buts_zero_p1 <= 1'b1;
      hit_cnt_r    <= '0;
      wrong_cnt_r  <= '0;
    end else begin
      hit_p1       <= hit_p0;
      buts_zero_p1 <= (bus.buts == '0);
      if (clear_cnt) begin
        hit_cnt_r   <= '0;
        wrong_cnt_r <= '0;
      end else begin
        if (hit_p0)   hit_cnt_r   <= sat_inc(hit_cnt_r);
        if (wrong_p0) wrong_cnt_r <= sat_inc(wrong_cnt_r);
      end
    end
  end

`ifdef LEARN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  logic [TMR_W-1:0] tmr;
  logic             tmr_last, miss_p0;
  logic [CNT_W-1:0] miss_cnt_r;

  assign tmr_last = (tmr == TMR_W'(TIMEOUT_CYC - 1));
  // A match in the final timeout cycle wins over the miss.
  assign miss_p0  = decide_en && !match && tmr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      miss_p1    <= 1'b0;
      miss_cnt_r <= '0;
    end else begin
      miss_p1 <= miss_p0;
      if (state != S_LISTEN) tmr <= '0;
      else if (!tmr_last)    tmr <= tmr + TMR_W'(1);
      if (clear_cnt)    miss_cnt_r <= '0;
      else if (miss_p0) miss_cnt_r <= sat_inc(miss_cnt_r);
    end
  end

  assign bus.miss     = miss_p1;
  assign bus.miss_cnt = miss_cnt_r;
`else
  assign miss_p1      = 1'b0;
  assign bus.miss     = 1'b0;
  assign bus.miss_cnt = '0;
`endif

  assign bus.hit       = hit_p1;
  assign bus.hit_cnt   = hit_cnt_r;
  assign bus.wrong_cnt = wrong_cnt_r;
endmodule

// File: tb/tb_learn_mode_tutor.sv
// Scoreboard bench for learn_mode_tutor; timeout scenarios follow LEARN_TIMEOUT_EN.
module tb_learn_mode_tutor;
  localparam int NUM_KEYS = 8, OCT_W = 2, CNT_W = 4, TIMEOUT_CYC = 16;
  localparam logic [1:0] K_HIT = 2'b10, K_MISS = 2'b01;

  typedef struct packed { logic [1:0] kind; logic [3:0] cnt; } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_rewind = 1'b0;
  int   rd_ptr = 0;
  int   n_cmp = 0, n_bad = 0;
  logic [9:0] song_note [32];
  logic       song_last [32];
  sb_t  sb_q[$];

  learn_mode_tutor_if #(.NUM_KEYS(NUM_KEYS), .OCT_W(OCT_W), .CNT_W(CNT_W)) bus ();

  learn_mode_tutor #(.NUM_KEYS(NUM_KEYS), .OCT_W(OCT_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // Song memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rewind) rd_ptr <= 0;
    else if (bus.read_en) begin
      bus.note_in   <= song_note[rd_ptr];
      bus.note_last <= song_last[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h, expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && (bus.hit || bus.miss)) begin
      if (sb_q.size() == 0) check("sb_unexpected_pulse", {bus.hit, bus.miss}, 0);
      else begin
        e = sb_q.pop_front();
        check("sb_kind", {bus.hit, bus.miss}, e.kind);
        check("sb_cnt", bus.hit ? bus.hit_cnt : bus.miss_cnt, e.cnt);
      end
    end
  end

  task automatic push_exp(input logic [1:0] kind, input int cnt);
    sb_t e;
    e.kind = kind;
    e.cnt  = cnt[3:0];
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_song();
    for (int i = 0; i < 32; i++) begin
      song_note[i] = '0;
      song_last[i] = 1'b0;
    end
    mem_rewind = 1'b1;
    cycle();
    mem_rewind = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  // Waits for the FETCH read_en pulse, then lands in the first LISTEN cycle.
  task automatic fetch_to_listen(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.read_en) break;
    end
    check(tag, bus.read_en, 1);
    repeat (3) cycle();
  endtask

  task automatic wait_hit(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.hit) break;
    end
    check(tag, bus.hit, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    check(tag, bus.done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.buts = '0; bus.octave = 2'd1;
    clear_song();
    @(negedge clk);
    check("rst_read_en", bus.read_en, 0);
    check("rst_hit_miss", {bus.hit, bus.miss}, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    check("rst_counters", {bus.hit_cnt, bus.miss_cnt, bus.wrong_cnt}, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Correct press at minimum note period.
    song_note[0] = 10'h201; song_last[1] = 1'b1;
    push_exp(K_HIT, 1);
    do_start();
    fetch_to_listen("t1_read_en");
    bus.buts = 8'h01;
    cycle();
    @(negedge clk);
    check("t1_hit_4th_cycle", bus.hit, 1);
    cycle();
    bus.buts = 8'h00;
    @(negedge clk);
    check("t1_read_en_after_hit", bus.read_en, 1);
    wait_done("t1_done", 10);
    check("t1_busy_in_done", bus.busy, 0);

    // Repeated note: held key must be released before the second hit.
    clear_song();
    song_note[0] = 10'h201; song_note[1] = 10'h201; song_last[2] = 1'b1;
    push_exp(K_HIT, 1);
    do_start();
    @(negedge clk);
    check("t2_start_clears", bus.hit_cnt, 0);
    repeat (3) cycle();
    bus.buts = 8'h01;
    wait_hit("t2_hit1");
    repeat (12) cycle();
    check("t2_no_second_hit", bus.hit_cnt, 1);
    bus.buts = 8'h00;
    cycle();
    push_exp(K_HIT, 2);
    bus.buts = 8'h01;
    wait_hit("t2_hit2");
    bus.buts = 8'h00;
    wait_done("t2_done", 20);

    // Rest note auto-advance, wrong press then correct, then abort in FETCH.
    clear_song();
    song_note[0] = 10'h001; song_note[1] = 10'h201; song_note[2] = 10'h201; song_last[3] = 1'b1;
    push_exp(K_HIT, 1);
    do_start();
    wait_hit("t3_rest_auto_hit");
    fetch_to_listen("t3_read_en");
    bus.buts = 8'h02;
    repeat (2) cycle();
    bus.buts = 8'h00;
    cycle();
    push_exp(K_HIT, 2);
    bus.buts = 8'h01;
    wait_hit("t3_hit_after_wrong");
    check("t3_wrong_cnt", bus.wrong_cnt, 1);
    bus.buts = 8'h00;
    cycle();
    bus.abort = 1'b1;
    @(negedge clk);
    check("t3_abort_no_read_en", bus.read_en, 0);
    cycle();
    bus.abort = 1'b0;
    @(negedge clk);
    check("t3_abort_idle", {bus.busy, bus.done}, 0);
    check("t3_abort_hold_cnt", {bus.hit_cnt, bus.wrong_cnt}, {4'd2, 4'd1});
    repeat (3) cycle();
    check("t3_stays_idle", {bus.busy, bus.read_en}, 0);

    // Timeout behaviour.
    clear_song();
`ifdef LEARN_TIMEOUT_EN
    for (int i = 0; i < 20; i++) song_note[i] = 10'h201;
    song_last[20] = 1'b1;
    for (int i = 1; i <= 20; i++) push_exp(K_MISS, (i > 15) ? 15 : i);
    do_start();
    fetch_to_listen("t4_read_en");
    repeat (15) cycle();
    @(negedge clk);
    check("t4_no_early_miss", bus.miss, 0);
    cycle();
    @(negedge clk);
    check("t4_miss_at_16", bus.miss, 1);
    wait_done("t4_done", 600);
    check("t4_miss_saturated", bus.miss_cnt, 15);
    check("t4_no_hits", bus.hit_cnt, 0);
`else
    begin
      int seen;
      seen = 0;
      song_note[0] = 10'h201; song_last[1] = 1'b1;
      do_start();
      fetch_to_listen("t4_read_en");
      repeat (1000) begin
        @(negedge clk);
        if (bus.miss) seen++;
      end
      check("t4_no_miss_1000", seen, 0);
      check("t4_miss_cnt_zero", bus.miss_cnt, 0);
      push_exp(K_HIT, 1);
      bus.buts = 8'h01;
      wait_hit("t4_late_hit");
      bus.buts = 8'h00;
      wait_done("t4_done", 20);
    end
`endif

    // Asynchronous reset in LISTEN, then restart.
    clear_song();
    song_note[0] = 10'h201; song_note[1] = 10'h201; song_last[2] = 1'b1;
    push_exp(K_HIT, 1);
    do_start();
    fetch_to_listen("t5_read_en");
    bus.buts = 8'h01;
    wait_hit("t5_hit");
    bus.buts = 8'h00;
    fetch_to_listen("t5_read_en2");
    rst_n = 1'b0;
    #2;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_outputs", {bus.read_en, bus.hit, bus.miss, bus.done}, 0);
    check("t5_rst_hit_cnt", bus.hit_cnt, 0);
    cycle();
    rst_n = 1'b1;
    clear_song();
    song_note[0] = 10'h201; song_last[1] = 1'b1;
    do_start();
    @(negedge clk);
    check("t5_restart_read_en", bus.read_en, 1);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    @(negedge clk);
    check("t5_abort_idle", bus.busy, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/learn_mode_tutor.md
# learn_mode_tutor

Parametrised learn-mode controller for the keyboard player. It walks a stored song note by note, pulsing `read_en` to fetch each note from the song memory. It advances when the player presses the matching key combination, and keeps hit, miss and wrong-press statistics for the display block. It replaces the fixed 8-key matcher with a configurable key/octave width. It adds a release-before-next-note rule, explicit start/abort/done handshakes and per-note timeout.

## Interface
- `NUM_KEYS`, default 8: number of note buttons.
- `OCT_W`, default 2: octave field width.
- `CNT_W`, default 8: width of each statistics counter.
- `TIMEOUT_CYC`, default 100_000_000: LISTEN cycles before a note is declared missed. Must be ≥ 2.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `start` input, 1 bit: one-cycle pulse that begins a lesson.
- `abort` input, 1 bit: level; returns the block to IDLE.
- `buts` input, `NUM_KEYS` bits: debounced, synchronous key levels.
- `octave` input, `OCT_W` bits: current octave selection.
- `note_in` input, `NUM_KEYS+OCT_W` bits: note from memory.
  - `note_in[NUM_KEYS+OCT_W-1-i]` = key i.
  - `note_in[OCT_W-1:0]` = octave.
- `note_last` input, 1 bit: memory flag; the note on `note_in` is the song terminator.
- `read_en` output, 1 bit: one-cycle fetch-next pulse to memory.
- `hit` output, 1 bit: one-cycle pulse on a correct press.
- `miss` output, 1 bit: one-cycle pulse on a timeout.
- `busy` output, 1 bit: high in any state except IDLE and DONE.
- `done` output, 1 bit: high while in DONE.
- `hit_cnt`, `miss_cnt`, `wrong_cnt` outputs, `CNT_W` bits each: saturating statistics counters.

## Operation
- States:
  - IDLE: `start` → FETCH. Clears all three counters.
  - FETCH: `read_en`=1 → LOAD.
  - LOAD: `note_in` and `note_last` are valid this cycle.
    - `note_last`=1 → DONE.
    - `note_last`=0 → ARM.
  - ARM: waits for `buts`==0 → LISTEN. The timeout counter is cleared on entry to LISTEN.
  - LISTEN:
    - match → `hit` pulse, `hit_cnt`+1 → FETCH.
    - timeout → `miss` pulse, `miss_cnt`+1 → FETCH.
  - DONE: holds until `start` (→ FETCH, counters cleared) or `abort` (→ IDLE).
- Match: `{buts` reversed to memory order, `octave}` == `note_in`, evaluated every LISTEN cycle.
- Wrong press:
  - Condition: in LISTEN, `buts` goes from 0 to nonzero and the value does not match.
  - Action: `wrong_cnt`+1.
  - Only one increment per press; another requires full release first.
- Rest note: key field all zero. It matches on the first LISTEN cycle with `buts`==0, i.e. auto-advance.
- Counters saturate at 2^CNT_W−1 and never wrap.
- `abort`:
  - Has priority over every transition; next state is IDLE.
  - Suppresses `read_en`, `hit` and `miss` in the same cycle.
  - Counters hold their values.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset (asynchronous):
  - state = IDLE.
  - `read_en`, `hit`, `miss`, `busy`, `done` = 0.
  - All counters = 0.
- Memory latency is one cycle: a `read_en` pulse in cycle t gives valid `note_in` in cycle t+1. It is held until the next `read_en`.
- Minimum note period, with keys already released: FETCH, LOAD, ARM, LISTEN → `hit` in the 4th cycle after the FETCH cycle. The next `read_en` follows the cycle after `hit`.
- `hit`, `miss` and counter updates are registered: outputs change one cycle after the deciding condition.
- Timeout: `miss` fires when `TIMEOUT_CYC` consecutive LISTEN cycles pass without a match.
- Simultaneous events:
  - Match in the final timeout cycle counts as a hit, not a miss.
  - Match and wrong press are mutually exclusive by definition.
  - `start` and `abort` together → IDLE.

## Configuration
- `LEARN_TIMEOUT_EN`
  - Defined: timeout counter and `miss` path as described.
  - Undefined: no timeout. LISTEN waits indefinitely, `miss` is tied to 0, `miss_cnt` is tied to 0, and no timeout counter is synthesised.

## Test plan
Scenarios use `NUM_KEYS`=8, `OCT_W`=2, `CNT_W`=4, `TIMEOUT_CYC`=16 unless stated.

- Reset mid-lesson: assert `rst_n`=0 in LISTEN → all outputs 0 immediately and state IDLE; `start` then produces `read_en` on the next cycle.
- Correct press:
  - Stimulus: `note_in`=10'h201 (key 0, octave 1), `octave`=1, `buts`=8'h01 after ARM.
  - Response: one `hit` pulse, `hit_cnt`=1, `read_en` the following cycle.
- Repeated note:
  - Stimulus: two consecutive 10'h201 notes with `buts` held at 8'h01.
  - Response: only one hit. The second hit occurs only after `buts`=0 then 8'h01.
- Wrong press, then correct: press 8'h02, release, press 8'h01 → `wrong_cnt`=1, `hit_cnt`=1.
- Timeout:
  - Stimulus: no press for 16 LISTEN cycles.
  - Response: `miss` pulse, `miss_cnt`=1.
  - Repeat 20 times: `miss_cnt` saturates at 15.
  - With `LEARN_TIMEOUT_EN` undefined: no `miss` after 1000 cycles.
- End and abort:
  - `note_last`=1 in LOAD → `done`=1, `busy`=0.
  - `abort` during FETCH → no `read_en`, next state IDLE, counters unchanged.
